// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute, drives datapath controls, counts retired instructions.
// Optional feature: define MULTICYCLE_CTRL_JUMP_EN to decode op 0x02 as an unconditional jump.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func_code,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSrc,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [3:0]       alu_ctrl,
  output logic             RegDst,
  output logic             MemReg,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_n;
  logic   retire_c;

  // zero only qualifies PCWriteCond inside the datapath; the FSM itself does not branch on it
  logic unused_zero;
  assign unused_zero = zero;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset)         retired <= '0;
    else if (retire_c) retired <= retired + CNT_W'(1);
  end

  assign state = state_q;

  // Next state and datapath controls; everything held low while reset is asserted
  always_comb begin
    state_n     = state_q;
    retire_c    = 1'b0;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'b00;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    alu_ctrl    = 4'b0000;
    RegDst      = 1'b0;
    MemReg      = 1'b0;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (mem_ack) begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            AluSrcB  = 2'b01;
            alu_ctrl = ALU_ADD;
            state_n  = S_DECODE;
          end
        end
        S_DECODE: begin
          AluSrcB  = 2'b11;
          alu_ctrl = ALU_ADD;
          case (op)
            OP_RTYPE:      state_n = S_EXEC;
            OP_LW, OP_SW:  state_n = S_MEMADR;
            OP_BEQ:        state_n = S_BRANCH;
            OP_ADDI:       state_n = S_ADDIEX;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OP_J:          state_n = S_JUMP;
`endif
            default: begin
              illegal = 1'b1;
              state_n = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          AluSrcA  = 1'b1;
          AluSrcB  = 2'b10;
          alu_ctrl = ALU_ADD;
          state_n  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ack) state_n = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          retire_c = 1'b1;
          state_n  = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ack) begin
            retire_c = 1'b1;
            state_n  = S_FETCH;
          end
        end
        S_EXEC: begin
          AluSrcA = 1'b1;
          state_n = S_ALUWB;
          case (func_code)
            6'h20:   alu_ctrl = ALU_ADD;
            6'h22:   alu_ctrl = ALU_SUB;
            6'h24:   alu_ctrl = ALU_AND;
            6'h25:   alu_ctrl = ALU_OR;
            6'h27:   alu_ctrl = ALU_NOR;
            6'h2A:   alu_ctrl = ALU_SLT;
            default: begin
              illegal = 1'b1;
              state_n = S_FETCH;
            end
          endcase
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          MemReg   = 1'b1;
          retire_c = 1'b1;
          state_n  = S_FETCH;
        end
        S_BRANCH: begin
          AluSrcA     = 1'b1;
          alu_ctrl    = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = 2'b01;
          retire_c    = 1'b1;
          state_n     = S_FETCH;
        end
`ifdef MULTICYCLE_CTRL_JUMP_EN
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSrc    = 2'b10;
          retire_c = 1'b1;
          state_n  = S_FETCH;
        end
`endif
        S_ADDIEX: begin
          AluSrcA  = 1'b1;
          AluSrcB  = 2'b10;
          alu_ctrl = ALU_ADD;
          state_n  = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          MemReg   = 1'b1;
          retire_c = 1'b1;
          state_n  = S_FETCH;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction cycle model predicts every cycle's outputs.
// Honours MULTICYCLE_CTRL_JUMP_EN when predicting op 0x02.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int LOGN = 4096;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3,
                         ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6, ST_ALUWB = 4'd7,
                         ST_BRANCH = 4'd8, ST_JUMP = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11;

  typedef struct packed {
    logic [3:0]       st;
    logic             mem_req, mem_read, mem_write, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0]       pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [3:0]       alu;
    logic             regdst, memreg, regwrite, ill;
    logic [CNT_W-1:0] ret;
  } obs_t;

  logic clock, reset, zero, mem_ack;
  logic [5:0] op, func_code;
  logic mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, AluSrcA;
  logic RegDst, MemReg, RegWrite, illegal;
  logic [1:0] PCSrc, AluSrcB;
  logic [3:0] alu_ctrl, state;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .op(op), .func_code(func_code), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSrc(PCSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .alu_ctrl(alu_ctrl),
    .RegDst(RegDst), .MemReg(MemReg), .RegWrite(RegWrite), .state(state),
    .illegal(illegal), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int ncmp   = 0;
  obs_t expq[$];
  obs_t obs_log[LOGN];
  logic [CNT_W-1:0] rcnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t blank(input logic [3:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    e.ret = rcnt;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs that cycle must show
  task automatic step(input logic rst, input logic ack, input obs_t e);
    reset = rst;
    mem_ack = ack;
    expq.push_back(e);
    pushed++;
    @(posedge clock);
    #1;
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction classes: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 jump, 6 illegal
  function automatic int kind_of(input logic [5:0] o);
    case (o)
      6'h00: return 0;
      6'h23: return 1;
      6'h2B: return 2;
      6'h04: return 3;
      6'h08: return 4;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      6'h02: return 5;
`endif
      default: return 6;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20: return {1'b1, 4'b0010};
      6'h22: return {1'b1, 4'b0110};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h27: return {1'b1, 4'b1100};
      6'h2A: return {1'b1, 4'b0111};
      default: return 5'b0;
    endcase
  endfunction

  task automatic retire();
    rcnt = CNT_W'(rcnt + 1'b1);
  endtask

  task automatic mem_phase(input logic [3:0] s, input logic wr, input int md);
    obs_t e;
    e = blank(s);
    e.mem_req = 1'b1;
    e.iord = 1'b1;
    e.mem_read = ~wr;
    e.mem_write = wr;
    for (int i = 0; i < md; i++) step(1'b0, 1'b0, e);
    step(1'b0, 1'b1, e);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fd, input int md);
    obs_t e;
    logic [4:0] a;
    int k;
    op = o; func_code = f; zero = z;
    k = kind_of(o);
    e = blank(ST_FETCH);
    e.mem_req = 1'b1; e.mem_read = 1'b1;
    for (int i = 0; i < fd; i++) step(1'b0, 1'b0, e);
    e.irwrite = 1'b1; e.pcwrite = 1'b1; e.alusrcb = 2'b01; e.alu = 4'b0010;
    step(1'b0, 1'b1, e);
    e = blank(ST_DECODE);
    e.alusrcb = 2'b11; e.alu = 4'b0010; e.ill = (k == 6);
    step(1'b0, rnd1(), e);
    case (k)
      0: begin
        a = alu_of(f);
        e = blank(ST_EXEC);
        e.alusrca = 1'b1; e.alu = a[3:0]; e.ill = ~a[4];
        step(1'b0, rnd1(), e);
        if (a[4]) begin
          e = blank(ST_ALUWB);
          e.regwrite = 1'b1; e.regdst = 1'b1; e.memreg = 1'b1;
          step(1'b0, rnd1(), e);
          retire();
        end
      end
      1, 2: begin
        e = blank(ST_MEMADR);
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = 4'b0010;
        step(1'b0, rnd1(), e);
        if (k == 1) begin
          mem_phase(ST_MEMRD, 1'b0, md);
          e = blank(ST_MEMWB);
          e.regwrite = 1'b1;
          step(1'b0, rnd1(), e);
        end else begin
          mem_phase(ST_MEMWR, 1'b1, md);
        end
        retire();
      end
      3: begin
        e = blank(ST_BRANCH);
        e.alusrca = 1'b1; e.alu = 4'b0110; e.pcwritecond = 1'b1; e.pcsrc = 2'b01;
        step(1'b0, rnd1(), e);
        retire();
      end
      4: begin
        e = blank(ST_ADDIEX);
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = 4'b0010;
        step(1'b0, rnd1(), e);
        e = blank(ST_ADDIWB);
        e.regwrite = 1'b1; e.memreg = 1'b1;
        step(1'b0, rnd1(), e);
        retire();
      end
      5: begin
        e = blank(ST_JUMP);
        e.pcwrite = 1'b1; e.pcsrc = 2'b10;
        step(1'b0, rnd1(), e);
        retire();
      end
      default: ;
    endcase
  endtask

  task automatic run_random();
    logic [5:0] o, f;
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1: o = 6'h00;
      2: o = 6'h23;
      3: o = 6'h2B;
      4: o = 6'h04;
      5: o = 6'h08;
      6: o = 6'h02;
      7: o = 6'h3F;
      default: o = 6'($urandom);
    endcase
    r = $urandom_range(0, 7);
    case (r)
      0: f = 6'h20;
      1: f = 6'h22;
      2: f = 6'h24;
      3: f = 6'h25;
      4: f = 6'h27;
      5: f = 6'h2A;
      default: f = 6'($urandom);
    endcase
    run_instr(o, f, rnd1(), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Compare process: every queued cycle checked against the DUT on the falling edge
  initial begin
    obs_t act, e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        act = '{st: state, mem_req: mem_req, mem_read: MemRead, mem_write: MemWrite,
                iord: IorD, irwrite: IRWrite, pcwrite: PCWrite, pcwritecond: PCWriteCond,
                pcsrc: PCSrc, alusrca: AluSrcA, alusrcb: AluSrcB, alu: alu_ctrl,
                regdst: RegDst, memreg: MemReg, regwrite: RegWrite, ill: illegal,
                ret: retired};
        chk($sformatf("cycle%0d", ncmp), 64'(act), 64'(e));
        if (ncmp < LOGN) obs_log[ncmp] = act;
        ncmp++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0, rc;
    obs_t e;
    reset = 1'b1; mem_ack = 1'b0; zero = 1'b0; op = '0; func_code = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    step(1'b1, 1'b1, blank(ST_FETCH));

    // Directed: add, lw with 3-cycle ack delay, beq z=1/z=0, op 0x3F, op 0x02
    d0 = pushed;
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++) run_random();

    // Reset while a store is waiting for its ack
    op = 6'h2B; func_code = '0; zero = 1'b0;
    e = blank(ST_FETCH);
    e.mem_req = 1'b1; e.mem_read = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    e.alusrcb = 2'b01; e.alu = 4'b0010;
    step(1'b0, 1'b1, e);
    e = blank(ST_DECODE); e.alusrcb = 2'b11; e.alu = 4'b0010;
    step(1'b0, 1'b0, e);
    e = blank(ST_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = 4'b0010;
    step(1'b0, 1'b0, e);
    e = blank(ST_MEMWR); e.mem_req = 1'b1; e.mem_write = 1'b1; e.iord = 1'b1;
    step(1'b0, 1'b0, e);
    rc = pushed;
    step(1'b1, 1'b1, blank(ST_MEMWR));
    rcnt = '0;
    step(1'b1, 1'b1, blank(ST_FETCH));
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++) run_random();

    repeat (2) @(negedge clock);
    chk("queue_drained", 64'(expq.size()), 64'd0);

    // Literal pins on the model's key traces
    chk("reset_state", 64'({obs_log[0].st, obs_log[0].mem_req, obs_log[0].ret}), 64'({4'd0, 1'b0, 4'd0}));
    chk("add_states", 64'({obs_log[d0].st, obs_log[d0+1].st, obs_log[d0+2].st, obs_log[d0+3].st, obs_log[d0+4].st}),
        64'({4'd0, 4'd1, 4'd6, 4'd7, 4'd0}));
    chk("add_exec_alu", 64'(obs_log[d0+2].alu), 64'(4'b0010));
    chk("add_aluwb", 64'({obs_log[d0+3].regwrite, obs_log[d0+3].regdst, obs_log[d0+4].ret}), 64'({1'b1, 1'b1, 4'd1}));
    for (int k = 7; k <= 10; k++)
      chk($sformatf("lw_memrd%0d", k), 64'({obs_log[d0+k].st, obs_log[d0+k].mem_read, obs_log[d0+k].iord}),
          64'({4'd3, 1'b1, 1'b1}));
    chk("lw_memwb", 64'({obs_log[d0+11].st, obs_log[d0+11].regwrite, obs_log[d0+11].memreg}), 64'({4'd4, 1'b1, 1'b0}));
    chk("beq_z1", 64'({obs_log[d0+14].st, obs_log[d0+14].pcwritecond, obs_log[d0+14].pcsrc, obs_log[d0+15].ret}),
        64'({4'd8, 1'b1, 2'b01, 4'd3}));
    chk("beq_z0", 64'({obs_log[d0+17].st, obs_log[d0+17].pcwritecond, obs_log[d0+17].pcsrc, obs_log[d0+18].ret}),
        64'({4'd8, 1'b1, 2'b01, 4'd4}));
    chk("illegal_3f", 64'({obs_log[d0+19].st, obs_log[d0+19].ill, obs_log[d0+19].regwrite, obs_log[d0+19].mem_write,
        obs_log[d0+20].st, obs_log[d0+20].ret}), 64'({4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4}));
`ifdef MULTICYCLE_CTRL_JUMP_EN
    chk("op02_jump", 64'({obs_log[d0+22].st, obs_log[d0+22].pcwrite, obs_log[d0+22].pcsrc, obs_log[d0+23].ret}),
        64'({4'd9, 1'b1, 2'b10, 4'd5}));
`else
    chk("op02_illegal", 64'({obs_log[d0+21].ill, obs_log[d0+22].st, obs_log[d0+22].ret}), 64'({1'b1, 4'd0, 4'd4}));
`endif
    chk("rst_in_memwr", 64'({obs_log[rc].st, obs_log[rc].mem_req, obs_log[rc].mem_write}), 64'({4'd5, 1'b0, 1'b0}));
    chk("rst_after", 64'({obs_log[rc+1].st, obs_log[rc+1].mem_req, obs_log[rc+1].ret}), 64'({4'd0, 1'b0, 4'd0}));
    chk("rst_first_req", 64'({obs_log[rc+2].st, obs_log[rc+2].mem_req}), 64'({4'd0, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
